// File: rtl/timer_mode_controller.sv
// rtl/timer_mode_controller.sv - stopwatch/countdown timer control FSM with prescaled tick
// Optional feature macro: TIMER_AUTO_RELOAD_EN (countdown reloads from the latched preset instead of stopping)
module timer_mode_controller #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_sel,
    input  logic [WIDTH-1:0] preset,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             mode,
    output logic             expired
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             mode_q, mode_d;
    logic             expired_q, expired_d;

    logic tick;
    logic at_sat;
    logic at_one;
    logic end_tick;
    logic reload;
    logic finish;
    logic go;

`ifdef TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] preset_q, preset_d;
`endif

    // pause outranks start, so a start with pause held is not a start
    assign go       = start && !pause;
    assign tick     = (state_q == S_RUN) && (presc_q == PRESC_LAST);
    assign at_sat   = (count_q == {WIDTH{1'b1}});
    assign at_one   = (count_q == WIDTH'(1));
    assign end_tick = tick && (mode_q ? at_one : at_sat);

`ifdef TIMER_AUTO_RELOAD_EN
    assign reload = end_tick && mode_q && (preset_q != '0);
`else
    assign reload = 1'b0;
`endif

    assign finish = end_tick && !reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            mode_q    <= 1'b0;
            expired_q <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            preset_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            mode_q    <= mode_d;
            expired_q <= expired_d;
`ifdef TIMER_AUTO_RELOAD_EN
            preset_q  <= preset_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_d = (mode_sel && (preset == '0)) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    // terminal tick wins over a coincident pause so expired still fires
                    if (finish) begin
                        state_d = S_DONE;
                    end else if (pause) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (go) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        count_d   = count_q;
        presc_d   = presc_q;
        mode_d    = mode_q;
        expired_d = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        preset_d  = preset_q;
`endif
        if (clear) begin
            count_d = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        mode_d    = mode_sel;
                        presc_d   = '0;
                        count_d   = mode_sel ? preset : '0;
                        expired_d = mode_sel && (preset == '0);
`ifdef TIMER_AUTO_RELOAD_EN
                        preset_d  = preset;
`endif
                    end
                end
                S_RUN: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (reload) begin
`ifdef TIMER_AUTO_RELOAD_EN
                            count_d = preset_q;
`endif
                            expired_d = 1'b1;
                        end else if (mode_q) begin
                            count_d = count_q - WIDTH'(1);
                        end else if (!at_sat) begin
                            count_d = count_q + WIDTH'(1);
                        end
                        if (finish) begin
                            expired_d = 1'b1;
                        end
                    end
                end
                default: begin
                    count_d = count_q;
                    presc_d = presc_q;
                end
            endcase
        end
    end

    assign count   = count_q;
    assign state   = state_q;
    assign mode    = mode_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_timer_mode_controller.sv
// tb/tb_timer_mode_controller.sv - directed bench for timer_mode_controller with PRESCALE=4
module tb_timer_mode_controller;

    logic       clk;
    logic       rst;
    logic       mode_sel;
    logic [7:0] preset;
    logic       start;
    logic       pause;
    logic       clear;
    logic [7:0] count;
    logic [1:0] state;
    logic       mode;
    logic       expired;

    int n_checks = 0;
    int n_fails  = 0;

    timer_mode_controller #(.WIDTH(8), .PRESCALE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_sel (mode_sel),
        .preset   (preset),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .count    (count),
        .state    (state),
        .mode     (mode),
        .expired  (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [7:0] cnt, input logic ex);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_count"}, 32'(count), 32'(cnt));
        check({tag, "_expired"}, 32'(expired), 32'(ex));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode_sel = 1'b0; preset = 8'd0;
        start = 1'b0; pause = 1'b0; clear = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        check_all("reset", 2'b00, 8'd0, 1'b0);
        check("reset_mode", 32'(mode), 32'd0);

        // stopwatch: tick every 4 clks after entering RUN
        mode_sel = 1'b0;
        pulse_start();
        check_all("sw_run", 2'b01, 8'd0, 1'b0);
        step(4);
        check("sw_cnt1", 32'(count), 32'd1);
        step(4);
        check("sw_cnt2", 32'(count), 32'd2);
        step(4);
        check("sw_cnt3", 32'(count), 32'd3);
        step(2);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        check_all("sw_pause", 2'b10, 8'd3, 1'b0);
        step(20);
        check_all("sw_frozen", 2'b10, 8'd3, 1'b0);
        pulse_start();
        check_all("sw_resume", 2'b01, 8'd3, 1'b0);
        step(1);
        check("sw_phase_kept", 32'(count), 32'd4);
        pulse_clear();
        check_all("sw_clear", 2'b00, 8'd0, 1'b0);

        // pause coincident with tick, then clear+pause+start in RUN
        pulse_start();
        step(3);
        check("prio_pre_tick", 32'(count), 32'd0);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        check_all("prio_pause_tick", 2'b10, 8'd1, 1'b0);
        pulse_start();
        step(2);
        check("prio_in_run", 32'(state), 32'd1);
        clear = 1'b1; pause = 1'b1; start = 1'b1;
        step(1);
        clear = 1'b0; pause = 1'b0; start = 1'b0;
        check_all("prio_clear_all", 2'b00, 8'd0, 1'b0);

`ifndef TIMER_AUTO_RELOAD_EN
        // countdown from 3 to DONE
        mode_sel = 1'b1; preset = 8'd3;
        pulse_start();
        preset = 8'd99;
        mode_sel = 1'b0;
        check_all("cd_run", 2'b01, 8'd3, 1'b0);
        check("cd_mode", 32'(mode), 32'd1);
        step(4);
        check("cd_cnt2", 32'(count), 32'd2);
        step(4);
        check_all("cd_cnt1", 2'b01, 8'd1, 1'b0);
        step(4);
        check_all("cd_done", 2'b11, 8'd0, 1'b1);
        step(1);
        check_all("cd_done_hold", 2'b11, 8'd0, 1'b0);
        pulse_start();
        check_all("cd_start_ignored", 2'b11, 8'd0, 1'b0);
        pulse_clear();
        check_all("cd_clear", 2'b00, 8'd0, 1'b0);
        check("cd_mode_retained", 32'(mode), 32'd1);
`else
        // countdown with auto reload: 2,1,2,1 and expired every 8 clks
        mode_sel = 1'b1; preset = 8'd2;
        pulse_start();
        preset = 8'd50;
        check_all("ar_run", 2'b01, 8'd2, 1'b0);
        step(4);
        check_all("ar_cnt1", 2'b01, 8'd1, 1'b0);
        step(4);
        check_all("ar_reload1", 2'b01, 8'd2, 1'b1);
        step(1);
        check_all("ar_exp_low", 2'b01, 8'd2, 1'b0);
        step(3);
        check_all("ar_cnt1b", 2'b01, 8'd1, 1'b0);
        step(4);
        check_all("ar_reload2", 2'b01, 8'd2, 1'b1);
        pulse_clear();
        check_all("ar_clear", 2'b00, 8'd0, 1'b0);
`endif

        // countdown preset 0 goes straight to DONE
        mode_sel = 1'b1; preset = 8'd0;
        pulse_start();
        check_all("p0_done", 2'b11, 8'd0, 1'b1);
        step(1);
        check_all("p0_hold", 2'b11, 8'd0, 1'b0);
        pulse_clear();

        // stopwatch saturation at 255
        mode_sel = 1'b0;
        pulse_start();
        step(4 * 255);
        check_all("sat_255", 2'b01, 8'd255, 1'b0);
        step(4);
        check_all("sat_done", 2'b11, 8'd255, 1'b1);
        step(1);
        check_all("sat_hold", 2'b11, 8'd255, 1'b0);
        pulse_clear();

        // asynchronous reset mid-count
        pulse_start();
        step(20);
        check("ar_pre_count", 32'(count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 2'b00, 8'd0, 1'b0);
        check("async_rst_mode", 32'(mode), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        check_all("post_rst", 2'b00, 8'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
